// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for the 32-bit combinational ALU.
// Requests are handled one at a time, with operands read from a local register file and the result written back.
module alu_issue_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    input  logic              req_imm_en,
    input  logic [DATA_W-1:0] req_imm,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] alu_busA,
    output logic [DATA_W-1:0] alu_busB,
    output logic [2:0]        alu_control,
    input  logic [DATA_W-1:0] alu_dataOut,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              alu_negative,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [3:0]        flags,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OPER = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] rf [DEPTH];

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic              imm_en_q;
    logic [DATA_W-1:0] imm_q;

    logic accept;
    logic wb_write;

    // Handshake: a request transfers on any rising edge where req_valid and req_ready are both high.
    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == WB);
    assign wb_write   = (state == WB) && (op_q != 3'd0);
    assign dbg_data   = rf[dbg_addr];
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            alu_busA    <= '0;
            alu_busB    <= '0;
            alu_control <= 3'd0;
            resp_data   <= '0;
            flags       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= req_op;
                        rd_q     <= req_rd;
                        ra_q     <= req_ra;
                        rb_q     <= req_rb;
                        imm_en_q <= req_imm_en;
                        imm_q    <= req_imm;
                        state    <= OPER;
                    end
                end
                OPER: begin
                    alu_busA    <= rf[ra_q];
                    alu_busB    <= imm_en_q ? imm_q : rf[rb_q];
                    alu_control <= op_q;
                    state       <= EXEC;
                end
                EXEC: begin
                    // A NOP reports a zero result and leaves the flag register alone.
                    resp_data <= (op_q == 3'd0) ? '0 : alu_dataOut;
                    if (op_q != 3'd0) begin
                        flags <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                    end
                    state <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The writeback is assigned last, so it wins over an external load to the same address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (load_en) begin
                rf[load_addr] <= load_data;
            end
            if (wb_write) begin
                rf[rd_q] <= resp_data;
            end
        end
    end

endmodule
